// File: rtl/recirculator_gen.sv
// -----------------------------------------------------------------------------
// recirculator_gen
//
// Steers a multi-lane word stream either forward to the downstream mux path
// or back to the probe (recirculation).  The selector_idle input picks the
// mode.  Every change of mode passes through a one-cycle SWITCH state.  In
// that cycle no lane word is presented on either path, and the valid lanes
// arriving in that cycle are counted as dropped.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   data_in        LANES*DATA_W lane data, lane i at [i*DATA_W +: DATA_W]
//   valid_in       per-lane qualifier for data_in
//   selector_idle  1 = forward path, 0 = recirculate to probe
//   fwd_data       registered lane data to the downstream mux logic
//   fwd_valid      per-lane valid for fwd_data
//   rec_data       registered lane data returned to the probe
//   rec_valid      per-lane valid for rec_data
//   rec_count      per-lane saturating count of recirculated words
//   drop_count     saturating count of valid words discarded in SWITCH
//   state          current FSM state encoding
//
// States
//   state  | meaning
//   RST    | held in reset; all outputs and counters cleared
//   FWD    | capture lanes onto the forward path
//   RECIRC | capture lanes onto the recirculation path
//   SWITCH | one-cycle changeover; nothing captured, valid lanes dropped
//
// Outputs are decided by the state entered at an edge.  Inputs sampled at
// edge k are therefore visible on the outputs just after edge k.
// -----------------------------------------------------------------------------
module recirculator_gen #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LANES*DATA_W-1:0] data_in,
   input  logic [LANES-1:0]        valid_in,
   input  logic                    selector_idle,
   output logic [LANES*DATA_W-1:0] fwd_data,
   output logic [LANES-1:0]        fwd_valid,
   output logic [LANES*DATA_W-1:0] rec_data,
   output logic [LANES-1:0]        rec_valid,
   output logic [LANES*CNT_W-1:0]  rec_count,
   output logic [CNT_W-1:0]        drop_count,
   output logic [1:0]              state
);

   typedef enum logic [1:0] {
      ST_RST    = 2'b00,
      ST_FWD    = 2'b01,
      ST_RECIRC = 2'b10,
      ST_SWITCH = 2'b11
   } state_t;

   localparam int               POP_W   = $clog2(LANES + 1);
   localparam int               SUM_W   = CNT_W + POP_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                    r_state;
   state_t                    w_state_nxt;
   state_t                    w_mode;

   logic [LANES*DATA_W-1:0]   r_fwd_data;
   logic [LANES*DATA_W-1:0]   r_rec_data;
   logic [LANES-1:0]          r_fwd_valid;
   logic [LANES-1:0]          r_rec_valid;
   logic [CNT_W-1:0]          r_rec_cnt [LANES];
   logic [CNT_W-1:0]          r_drop_cnt;

   logic [LANES*DATA_W-1:0]   w_fwd_data_nxt;
   logic [LANES*DATA_W-1:0]   w_rec_data_nxt;
   logic [LANES-1:0]          w_fwd_valid_nxt;
   logic [LANES-1:0]          w_rec_valid_nxt;
   logic [CNT_W-1:0]          w_rec_cnt_nxt [LANES];
   logic [CNT_W-1:0]          w_drop_cnt_nxt;

   logic [POP_W-1:0]          w_pop;
   logic [SUM_W-1:0]          w_drop_sum;
   logic [CNT_W-1:0]          w_drop_sat;

   // ---------------------------------------------------------------------
   // Next-state logic.  From RST and from SWITCH the machine goes straight
   // to whichever mode the selector asks for.  So a one-cycle selector
   // glitch costs one SWITCH cycle and then returns to the old mode.
   // ---------------------------------------------------------------------
   always_comb begin
      w_mode      = selector_idle ? ST_FWD : ST_RECIRC;
      w_state_nxt = r_state;
      if (!reset) begin
         w_state_nxt = ST_RST;
      end else begin
         case (r_state)
            ST_RST,
            ST_SWITCH: w_state_nxt = w_mode;
            ST_FWD:    w_state_nxt = selector_idle ? ST_FWD : ST_SWITCH;
            ST_RECIRC: w_state_nxt = selector_idle ? ST_SWITCH : ST_RECIRC;
            default:   w_state_nxt = ST_RST;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------
   // Drop accounting: the number of valid lanes in a SWITCH cycle is added
   // to the drop counter.  The add is done one bit-group wider than the
   // counter so that any overflow can be detected and clamped.
   // ---------------------------------------------------------------------
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_pop = w_pop + POP_W'(valid_in[i]);
      end
   end

   assign w_drop_sum = {{POP_W{1'b0}}, r_drop_cnt} + {{CNT_W{1'b0}}, w_pop};
   assign w_drop_sat = (w_drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                      : w_drop_sum[CNT_W-1:0];

   // ---------------------------------------------------------------------
   // Datapath next values, chosen by the state being entered.  Valids
   // default to 0, so a lane word can only ever be on one path.  Data
   // buses hold unless their own path is selected.
   // ---------------------------------------------------------------------
   always_comb begin
      w_fwd_data_nxt  = r_fwd_data;
      w_rec_data_nxt  = r_rec_data;
      w_fwd_valid_nxt = '0;
      w_rec_valid_nxt = '0;
      w_drop_cnt_nxt  = r_drop_cnt;
      w_rec_cnt_nxt   = r_rec_cnt;
      case (w_state_nxt)
         ST_FWD: begin
            w_fwd_data_nxt  = data_in;
            w_fwd_valid_nxt = valid_in;
         end
         ST_RECIRC: begin
            w_rec_data_nxt  = data_in;
            w_rec_valid_nxt = valid_in;
            for (int i = 0; i < LANES; i++) begin
               if (valid_in[i] && (r_rec_cnt[i] != CNT_MAX)) begin
                  w_rec_cnt_nxt[i] = r_rec_cnt[i] + 1'b1;
               end
            end
         end
         ST_SWITCH: begin
            w_drop_cnt_nxt = w_drop_sat;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fwd_data  <= '0;
         r_rec_data  <= '0;
         r_fwd_valid <= '0;
         r_rec_valid <= '0;
         r_drop_cnt  <= '0;
         for (int i = 0; i < LANES; i++) begin
            r_rec_cnt[i] <= '0;
         end
      end else begin
         r_fwd_data  <= w_fwd_data_nxt;
         r_rec_data  <= w_rec_data_nxt;
         r_fwd_valid <= w_fwd_valid_nxt;
         r_rec_valid <= w_rec_valid_nxt;
         r_drop_cnt  <= w_drop_cnt_nxt;
         for (int i = 0; i < LANES; i++) begin
            r_rec_cnt[i] <= w_rec_cnt_nxt[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < LANES; g++) begin : g_rec_count
      assign rec_count[g*CNT_W +: CNT_W] = r_rec_cnt[g];
   end

   assign fwd_data   = r_fwd_data;
   assign fwd_valid  = r_fwd_valid;
   assign rec_data   = r_rec_data;
   assign rec_valid  = r_rec_valid;
   assign drop_count = r_drop_cnt;
   assign state      = r_state;

endmodule

// File: tb/tb_recirculator_gen.sv
module tb_recirculator_gen;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int CNT_W  = 16;
   localparam int CMAX   = 65535;

   logic                    clk;
   logic                    reset;
   logic [LANES*DATA_W-1:0] data_in;
   logic [LANES-1:0]        valid_in;
   logic                    selector_idle;
   logic [LANES*DATA_W-1:0] fwd_data;
   logic [LANES-1:0]        fwd_valid;
   logic [LANES*DATA_W-1:0] rec_data;
   logic [LANES-1:0]        rec_valid;
   logic [LANES*CNT_W-1:0]  rec_count;
   logic [CNT_W-1:0]        drop_count;
   logic [1:0]              state;

   int total = 0;
   int bad   = 0;

   // Reference model state, held at plain-integer level.
   // Modes: 0 reset, 1 forward, 2 recirculate, 3 switch.
   int          m_mode;
   logic [31:0] m_fd, m_rd;
   logic [3:0]  m_fv, m_rv;
   int          m_rc [4];
   int          m_drop;

   recirculator_gen #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .selector_idle (selector_idle),
      .fwd_data      (fwd_data),
      .fwd_valid     (fwd_valid),
      .rec_data      (rec_data),
      .rec_valid     (rec_valid),
      .rec_count     (rec_count),
      .drop_count    (drop_count),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_fd = '0; m_rd = '0; m_fv = '0; m_rv = '0; m_drop = 0;
      for (int i = 0; i < 4; i++) m_rc[i] = 0;
   endtask

   task automatic model_edge(input logic rst, input logic sel,
                             input logic [31:0] d, input logic [3:0] v);
      int want;
      int nxt;
      int ones;
      if (!rst) begin
         model_reset();
         return;
      end
      want = sel ? 1 : 2;
      if (m_mode == 0 || m_mode == 3 || m_mode == want) nxt = want;
      else nxt = 3;
      m_mode = nxt;
      m_fv = '0;
      m_rv = '0;
      if (nxt == 1) begin
         m_fd = d; m_fv = v;
      end else if (nxt == 2) begin
         m_rd = d; m_rv = v;
         for (int i = 0; i < 4; i++) if (v[i] && m_rc[i] < CMAX) m_rc[i]++;
      end else begin
         ones = 0;
         for (int i = 0; i < 4; i++) ones += int'(v[i]);
         m_drop = (m_drop + ones > CMAX) ? CMAX : m_drop + ones;
      end
   endtask

   task automatic check_all();
      logic [63:0] exp_rc;
      for (int i = 0; i < 4; i++) exp_rc[i*16 +: 16] = 16'(m_rc[i]);
      chk("state",      64'(state),      64'(m_mode));
      chk("fwd_data",   64'(fwd_data),   64'(m_fd));
      chk("fwd_valid",  64'(fwd_valid),  64'(m_fv));
      chk("rec_data",   64'(rec_data),   64'(m_rd));
      chk("rec_valid",  64'(rec_valid),  64'(m_rv));
      chk("rec_count",  rec_count,       exp_rc);
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("exclusive",  64'(fwd_valid & rec_valid), 64'd0);
   endtask

   task automatic step(input logic rst, input logic sel, input logic [31:0] d,
                       input logic [3:0] v, input bit do_chk);
      reset = rst; selector_idle = sel; data_in = d; valid_in = v;
      @(posedge clk);
      model_edge(rst, sel, d, v);
      #1;
      if (do_chk) check_all();
   endtask

   initial begin
      reset = 1'b0; selector_idle = 1'b0; data_in = '0; valid_in = '0;
      model_reset();

      // reset held with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'($urandom), $urandom, 4'($urandom), 1'b1);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", rec_count, 64'd0);

      // reset exit straight into forward
      step(1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1);
      chk("fwd_entry_state", 64'(state), 64'd1);
      chk("fwd_entry_data", 64'(fwd_data), 64'h44332211);
      chk("fwd_entry_valid", 64'(fwd_valid), 64'hF);

      // forward -> switch -> recirculate
      step(1'b1, 1'b0, $urandom, 4'b0101, 1'b1);
      chk("switch_state", 64'(state), 64'd3);
      chk("switch_drop", 64'(drop_count), 64'd2);
      chk("switch_valids", 64'({fwd_valid, rec_valid}), 64'd0);
      step(1'b1, 1'b0, 32'hDDCCBBAA, 4'hF, 1'b1);
      chk("recirc_state", 64'(state), 64'd2);
      chk("recirc_data", 64'(rec_data), 64'hDDCCBBAA);
      chk("recirc_counts", rec_count, 64'h0001_0001_0001_0001);
      chk("fwd_data_hold", 64'(fwd_data), 64'h44332211);

      // lane 3 only, ten cycles
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, $urandom, 4'b1000, 1'b1);
      chk("lane3_count", rec_count, 64'h000B_0001_0001_0001);

      // drive lane 3 counter into saturation, then confirm it sticks
      for (int i = 0; i < CMAX - 11; i++)
         step(1'b1, 1'b0, $urandom, 4'b1000, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, $urandom, 4'b1000, 1'b1);
      chk("lane3_sat", 64'(rec_count[63:48]), 64'hFFFF);
      chk("lane0_unchanged", 64'(rec_count[15:0]), 64'd1);

      // one-cycle selector glitch while recirculating
      step(1'b1, 1'b1, $urandom, 4'($urandom), 1'b1);
      chk("glitch_switch", 64'(state), 64'd3);
      chk("glitch_no_fwd", 64'(fwd_valid), 64'd0);
      step(1'b1, 1'b0, $urandom, 4'($urandom), 1'b1);
      chk("glitch_back", 64'(state), 64'd2);
      chk("glitch_no_fwd2", 64'(fwd_valid), 64'd0);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
              $urandom, 4'($urandom), 1'b1);

      // reset asserted while in SWITCH
      step(1'b1, 1'b1, $urandom, 4'hF, 1'b1);
      step(1'b1, 1'b1, $urandom, 4'hF, 1'b1);
      step(1'b1, 1'b0, $urandom, 4'hF, 1'b1);
      chk("pre_reset_switch", 64'(state), 64'd3);
      step(1'b0, 1'b1, $urandom, 4'hF, 1'b1);
      chk("mid_reset_state", 64'(state), 64'd0);
      chk("mid_reset_drop", 64'(drop_count), 64'd0);
      chk("mid_reset_counts", rec_count, 64'd0);
      chk("mid_reset_data", 64'({fwd_data, rec_data}), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
